// File: rtl/fip_32_div_seq.sv
// Multi-cycle signed fixed-point divider: o_z = i_x / i_y.
// Radix-2 restoring division on magnitudes, one quotient bit per cycle, sign applied at the end.
module fip_32_div_seq #(
    parameter int FRA_BITS = 16,
    parameter bit SAT      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [31:0] o_z,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_ovf,
    output logic        o_dz
);

    localparam int N  = 32 + FRA_BITS;
    localparam int CW = $clog2(N);

    localparam logic [N-1:0] C_MAX_POS = N'(64'h0000_0000_7FFF_FFFF);
    localparam logic [N-1:0] C_MAX_NEG = N'(64'h0000_0000_8000_0000);
    localparam logic [31:0]  C_FIP_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0]  C_FIP_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t         r_state;
    logic           r_sx;
    logic           r_sy;
    logic           r_dz;
    logic [31:0]    r_ay;
    logic [N-1:0]   r_d;
    logic [N-1:0]   r_q;
    logic [32:0]    r_r;
    logic [CW-1:0]  r_cnt;

    logic [31:0]    w_ax;
    logic [31:0]    w_ay;
    logic [32:0]    w_rp;
    logic           w_ge;
    logic [32:0]    w_rn;
    logic           w_neg;
    logic           w_ovf;
    logic [31:0]    w_wrap;
    logic [31:0]    w_z;

    // Magnitudes as unsigned: |0x80000000| stays 0x80000000 without overflow.
    always_comb begin
        w_ax = i_x[31] ? (~i_x + 32'd1) : i_x;
        w_ay = i_y[31] ? (~i_y + 32'd1) : i_y;
    end

    always_comb begin
        w_rp = 33'({r_r, r_d[N-1]});
        w_ge = (w_rp >= {1'b0, r_ay});
        w_rn = w_ge ? (w_rp - {1'b0, r_ay}) : w_rp;
    end

    always_comb begin
        w_neg  = r_sx ^ r_sy;
        w_ovf  = w_neg ? (r_q > C_MAX_NEG) : (r_q > C_MAX_POS);
        w_wrap = 32'(w_neg ? (~r_q + N'(1)) : r_q);
        if (r_dz) begin
            w_z = r_sx ? C_FIP_MIN : C_FIP_MAX;
        end else if (w_ovf && SAT) begin
            w_z = w_neg ? C_FIP_MIN : C_FIP_MAX;
        end else begin
            w_z = w_wrap;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_dz    <= 1'b0;
            r_ay    <= '0;
            r_d     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            o_z     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_dz    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_sx    <= i_x[31];
                        r_sy    <= i_y[31];
                        r_dz    <= (i_y == 32'd0);
                        r_ay    <= w_ay;
                        r_d     <= N'(w_ax) << FRA_BITS;
                        r_q     <= '0;
                        r_r     <= '0;
                        r_cnt   <= CW'(N - 1);
                        o_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_r <= w_rn;
                    r_d <= r_d << 1;
                    r_q <= {r_q[N-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIN: begin
                    o_z     <= w_z;
                    o_ovf   <= r_dz ? 1'b0 : w_ovf;
                    o_dz    <= r_dz;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fip_32_div_seq.sv
// Scoreboard bench for fip_32_div_seq: SAT=1 and SAT=0 instances driven in parallel,
// expected results from a 64-bit arithmetic reference model.
module tb_fip_32_div_seq;

    localparam int FRA = 16;
    localparam int LAT = 32 + FRA + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] x   = '0;
    logic [31:0] y   = '0;

    logic [31:0] z_s, z_w;
    logic        busy_s, valid_s, ovf_s, dz_s;
    logic        busy_w, valid_w, ovf_w, dz_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int busy_run = 0;

    typedef struct {
        logic [31:0] zs;
        logic [31:0] zw;
        logic        ovf;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fip_32_div_seq #(.FRA_BITS(FRA), .SAT(1'b1)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_y(y),
        .o_z(z_s), .o_busy(busy_s), .o_valid(valid_s), .o_ovf(ovf_s), .o_dz(dz_s)
    );

    fip_32_div_seq #(.FRA_BITS(FRA), .SAT(1'b0)) dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_y(y),
        .o_z(z_w), .o_busy(busy_w), .o_valid(valid_w), .o_ovf(ovf_w), .o_dz(dz_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        logic [31:0] ma, mb;
        longint unsigned q;
        logic neg;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        neg = a[31] ^ b[31];
        e.acc = acc;
        if (b == 32'd0) begin
            e.zs  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.zw  = e.zs;
            e.dz  = 1'b1;
            e.ovf = 1'b0;
        end else begin
            q = (64'(ma) << FRA) / 64'(mb);
            e.dz  = 1'b0;
            e.ovf = neg ? (q > 64'h8000_0000) : (q > 64'h7FFF_FFFF);
            e.zw  = neg ? 32'(-q) : 32'(q);
            e.zs  = e.ovf ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : e.zw;
        end
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_s) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: o_busy still 1 after %0d cycles", n);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        wait_idle();
        x  = a;
        y  = b;
        en = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (valid_s) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: o_valid=1 with no request outstanding, expected 0");
                end else begin
                    e = sb.pop_front();
                    chk("z_sat",   z_s, e.zs);
                    chk("ovf_sat", 32'(ovf_s), 32'(e.ovf));
                    chk("dz_sat",  32'(dz_s), 32'(e.dz));
                    chk("valid_wrap", 32'(valid_w), 32'd1);
                    chk("z_wrap",  z_w, e.zw);
                    chk("ovf_wrap", 32'(ovf_w), 32'(e.ovf));
                    chk("dz_wrap", 32'(dz_w), 32'(e.dz));
                    chk("latency", 32'(cyc - e.acc), 32'(LAT));
                    chk("busy_len", 32'(busy_run), 32'(LAT));
                    chk("busy_in_valid", 32'(busy_s), 32'd0);
                end
            end
            busy_run = busy_s ? busy_run + 1 : 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int mode;

        repeat (3) @(negedge clk);
        chk("rst_z",     z_s, 32'd0);
        chk("rst_busy",  32'(busy_s), 32'd0);
        chk("rst_valid", 32'(valid_s), 32'd0);
        chk("rst_ovf",   32'(ovf_s), 32'd0);
        chk("rst_dz",    32'(dz_s), 32'd0);
        rst = 1'b0;

        // Directed cases
        issue(32'h0003_0000, 32'h0002_0000);
        issue(32'hFFFF_0000, 32'h0003_0000);
        issue(32'h0001_0000, 32'hFFFD_0000);
        issue(32'hFFFF_0000, 32'hFFFD_0000);
        issue(32'h0001_0000, 32'h0000_0000);
        issue(32'hFFFF_0000, 32'h0000_0000);
        issue(32'h0000_0000, 32'h0000_0000);
        issue(32'h7FFF_FFFF, 32'h0000_0001);
        issue(32'h8000_0000, 32'h0001_0000);
        issue(32'h8000_0000, 32'hFFFF_0000);
        issue(32'h0000_0000, 32'hFFFF_0000);
        issue(32'h0000_0001, 32'h7FFF_FFFF);
        drain();

        // i_en held high: second accept lands in the first o_valid cycle
        @(negedge clk);
        x = 32'h0005_0000; y = 32'h0004_0000; en = 1'b1;
        sb.push_back(model(x, y, cyc + 1));
        @(negedge clk);
        x = 32'hFFF6_0000; y = 32'h0003_0000;
        wait_idle();
        sb.push_back(model(x, y, cyc + 1));
        @(negedge clk);
        en = 1'b0;
        drain();

        // Request during CALC is dropped
        issue(32'h0007_0000, 32'h0002_0000);
        repeat (10) @(negedge clk);
        x = 32'h1234_0000; y = 32'h0001_0000; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        drain();
        repeat (LAT + 5) @(negedge clk);

        // Asynchronous reset mid-division
        issue(32'h0009_0000, 32'h0002_0000);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  32'(busy_s), 32'd0);
        chk("abort_valid", 32'(valid_s), 32'd0);
        chk("abort_z",     z_s, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 10) @(negedge clk);
        issue(32'h0009_0000, 32'h0002_0000);
        drain();

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 4);
            ra = $urandom;
            rb = $urandom;
            case (mode)
                1: rb = rb & 32'h0003_FFFF;
                2: rb = (rb[0]) ? 32'hFFFF_FFFF : 32'h0000_0001;
                3: ra = ra & 32'h000F_FFFF;
                4: if (i % 3 == 0) rb = 32'd0;
                default: ;
            endcase
            if (rb[3]) rb = -rb;
            issue(ra, rb);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fip_32_div_seq.md
Name: fip_32_div_seq

Overview:
Multi-cycle signed Q(32-FRA_BITS).FRA_BITS fixed-point divider, o_z = i_x / i_y. It is the inverse operation of the fixed-point multiplier and replaces the single-cycle combinational divide on timing-critical paths, such as the vector-normal and intersection datapaths.
- Radix-2 restoring algorithm on operand magnitudes, sign applied at the end.
- Constant latency.
- Saturating output, with overflow and divide-by-zero flags.
- Handshake is en/busy/valid, matching the other fip_32 sequential blocks.

Parameters:
FRA_BITS, 16, fractional bits of operands and result.
SAT, 1, 1 = saturate result to FIP_MIN/FIP_MAX on overflow; 0 = wrap (low 32 bits of signed quotient).

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous reset, active-high.
i_en  input  1  start request; sampled only when o_busy=0.
i_x  input  32  signed dividend, fixed-point.
i_y  input  32  signed divisor, fixed-point.
o_z  output  32  signed quotient, valid while o_valid=1, held until next result.
o_busy  output  1  high while a division is in flight.
o_valid  output  1  one-cycle pulse, result present on o_z/o_ovf/o_dz.
o_ovf  output  1  quotient magnitude exceeded signed 32-bit range (independent of SAT).
o_dz  output  1  divisor was zero.

Behaviour:
- Reset: async on i_rst=1. State goes to IDLE. o_z=0, o_busy=0, o_valid=0, o_ovf=0, o_dz=0. Internal remainder, quotient and counter are cleared. Reset mid-operation aborts the division; no o_valid follows.
- N = 32+FRA_BITS iterations (48 at default).
- IDLE: o_busy=0. On a rising edge with i_en=1:
  - Register sx=sign(i_x), sy=sign(i_y).
  - Register |i_x| and |i_y| as 32-bit unsigned, so |FIP_MIN| = 0x80000000 exactly.
  - Register dz=(i_y==0).
  - Dividend D = |i_x| << FRA_BITS (N bits). Remainder R=0, counter=N-1.
  - Go to CALC.
- CALC: o_busy=1. Each edge performs one restoring step:
  - R' = {R, next MSB of D}; if R' >= |y| then R = R' - |y| and shift in q=1, else R = R' and shift in q=0.
  - R is 33 bits wide.
  - After the step with counter=0, go to FIN.
  - i_en is ignored.
- FIN: o_busy=1. One edge, producing the result from the N-bit quotient magnitude Q:
  - neg = sx XOR sy.
  - ovf = (neg=0 and Q > 0x7FFFFFFF) or (neg=1 and Q > 0x80000000).
  - dz: o_z = 0x7FFFFFFF if sx=0, else 0x80000000; o_dz=1, o_ovf=0. This applies for any SAT setting.
  - Else, ovf with SAT=1: o_z = neg ? 0x80000000 : 0x7FFFFFFF.
  - Else: o_z = low 32 bits of (neg ? -Q : Q).
  - Rounding is truncation toward zero.
  - Set o_valid=1 and go to IDLE.
- Latency: the accepting edge is E0. o_valid is high for exactly the cycle after edge E(N+1), i.e. N+1 edges later (49 at default). o_busy is high from after E0 until after E(N+1).
- o_valid drops on the next edge. o_z, o_ovf and o_dz hold until the next FIN.
- Back-to-back: o_busy=0 in the o_valid cycle. An i_en in that cycle is accepted, giving a throughput of one result per N+2 cycles.
- i_en while o_busy=1 is dropped, with no queueing. Operands are captured at acceptance; i_x/i_y may change afterward.
- Zero dividend: o_z=0, no flags.

Test Plan:
- Basic: x=0x00030000 (3.0), y=0x00020000 (2.0), i_en pulse -> o_z=0x00018000 exactly 49 edges after accept, o_ovf=0, o_dz=0, o_busy high for 49 cycles.
- Sign/truncation: x=0xFFFF0000 (-1.0), y=0x00030000 (3.0) -> o_z=0xFFFFAAAB. Swapping signs (x=+1.0, y=-3.0) gives the same result. x=-1.0, y=-3.0 -> 0x00005555.
- Divide by zero: x=0x00010000, y=0 -> o_z=0x7FFFFFFF, o_dz=1. x=0xFFFF0000, y=0 -> 0x80000000, o_dz=1. x=0, y=0 -> 0x7FFFFFFF, o_dz=1.
- Overflow:
  - x=0x7FFFFFFF, y=0x00000001 -> o_z=0x7FFFFFFF, o_ovf=1.
  - x=0x80000000, y=0x00010000 -> o_z=0x80000000, o_ovf=0.
  - x=0x80000000, y=0xFFFF0000 -> o_z=0x7FFFFFFF, o_ovf=1.
  - With SAT=0, x=0x80000000, y=0xFFFF0000 -> o_z=0x80000000, o_ovf=1.
- Handshake:
  - Hold i_en=1 throughout with different operands -> second accept happens in the o_valid cycle of the first, giving results on cycles 49 and 99.
  - Pulse i_en mid-CALC -> request ignored, only one o_valid.
- Reset: assert i_rst asynchronously (between edges) at iteration 20 -> o_busy=0, o_valid=0, o_z=0 immediately. No o_valid afterward. A new request after release returns the correct result.
